// File: rtl/r5fp_round_to_int_unit.sv
// r5fp_round_to_int_unit
// Rounds an IEEE-754 binary float to an integral value in the same format
// (FROUND semantics) under a dynamic rounding mode. The datapath is purely
// combinational and feeds a single output register stage. It has three parts:
// exponent widen, rounding post-process, and exponent narrow.
module r5fp_round_to_int_unit #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic [EXP_W+SIG_W:0]   a_i,
  input  logic [2:0]             rnd_i,
  output logic                   valid_o,
  output logic [EXP_W+SIG_W:0]   z_o,
  output logic [7:0]             status_o
);

  localparam int W     = EXP_W + SIG_W + 1;
  localparam int MW    = SIG_W + 1;
  localparam int EW    = EXP_W + 1;
  localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
  localparam int LIM_I  = BIAS_I + SIG_W;

  localparam logic [EW-1:0]    BIAS_W = BIAS_I[EW-1:0];
  localparam logic [EW-1:0]    LIM_W  = LIM_I[EW-1:0];
  localparam logic [EXP_W-1:0] BIAS_X = BIAS_I[EXP_W-1:0];
  localparam logic [EW-1:0]    ONE_E  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] ONE_X  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0]    ONE_M  = {{(MW-1){1'b0}}, 1'b1};

  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  logic             signA;
  logic [EXP_W-1:0] expA;
  logic [SIG_W-1:0] fracA;
  logic [EW-1:0]    expWide;
  logic             isNaN, isInf, isZero, isIntegral, isFrac, halfExp;
  logic [EW-1:0]    shiftAmt;
  logic [MW-1:0]    mant, incr, halfBit, discardMask, trunc, sum;
  logic             guard, sticky, lsb, inexactMid;
  logic             upMid, upFrac, carry;
  logic [W-1:0]     zNext;
  logic [7:0]       statusNext;

  // Operand classification, with the exponent widened by one bit so the
  // integral-limit compare cannot wrap. Subnormals need no renormalisation:
  // they always land in the |a|<1 branch, where only sign and "nonzero" matter.
  always_comb begin
    signA      = a_i[W-1];
    expA       = a_i[W-2:SIG_W];
    fracA      = a_i[SIG_W-1:0];
    expWide    = {1'b0, expA};
    isNaN      = (&expA) & (|fracA);
    isInf      = (&expA) & ~(|fracA);
    isZero     = ~(|expA) & ~(|fracA);
    isIntegral = expWide >= LIM_W;
    isFrac     = expWide < BIAS_W;
    halfExp    = expWide == (BIAS_W - ONE_E);
  end

  // Rounding post-process for 1 <= |a| < 2^SIG_W. The discard position is
  // given by shiftAmt = SIG_W - (exp - bias), which is always in 1..SIG_W here.
  always_comb begin
    shiftAmt    = LIM_W - expWide;
    mant        = {|expA, fracA};
    incr        = ONE_M << shiftAmt;
    halfBit     = incr >> 1;
    discardMask = incr - ONE_M;
    guard       = |(mant & halfBit);
    sticky      = |(mant & (halfBit - ONE_M));
    lsb         = |(mant & incr);
    inexactMid  = |(mant & discardMask);
    trunc       = mant & ~discardMask;
    case (rnd_i)
      RM_RTZ:  upMid = 1'b0;
      RM_RDN:  upMid = signA & inexactMid;
      RM_RUP:  upMid = ~signA & inexactMid;
      RM_RMM:  upMid = guard;
      default: upMid = guard & (sticky | lsb);
    endcase
    // A carry out of the hidden bit wraps sum to zero, which means the
    // result is the next power of two.
    sum   = trunc + (upMid ? incr : '0);
    carry = ~sum[SIG_W];
  end

  // Round-up decision for |a| < 1. The result is either 0 or 1.0.
  always_comb begin
    case (rnd_i)
      RM_RTZ:  upFrac = 1'b0;
      RM_RDN:  upFrac = signA;
      RM_RUP:  upFrac = ~signA;
      RM_RMM:  upFrac = halfExp;
      default: upFrac = halfExp & (|fracA);
    endcase
  end

  // Result selection and exponent narrowing back to EXP_W. The sign is kept
  // on every non-NaN path, including zero results.
  always_comb begin
    zNext      = a_i;
    statusNext = '0;
    if (isNaN) begin
      zNext         = {1'b0, {EXP_W{1'b1}}, 1'b1, {(SIG_W-1){1'b0}}};
      statusNext[2] = ~fracA[SIG_W-1];
    end else if (isInf | isZero | isIntegral) begin
      zNext         = a_i;
      statusNext[0] = isZero;
      statusNext[1] = isInf;
    end else if (isFrac) begin
      zNext         = upFrac ? {signA, BIAS_X, {SIG_W{1'b0}}} : {signA, {(W-1){1'b0}}};
      statusNext[0] = ~upFrac;
      statusNext[5] = 1'b1;
    end else begin
      zNext         = {signA, (carry ? expA + ONE_X : expA), sum[SIG_W-1:0]};
      statusNext[5] = inexactMid;
    end
  end

  // Output register. The result and status hold when no new operand arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_o  <= 1'b0;
      z_o      <= '0;
      status_o <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        z_o      <= zNext;
        status_o <= statusNext;
      end
    end
  end

endmodule

// File: tb/tb_r5fp_round_to_int_unit.sv
// Directed testbench for r5fp_round_to_int_unit (FP32 configuration).
module tb_r5fp_round_to_int_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [2:0]  rnd_i = '0;
  logic        valid_o;
  logic [31:0] z_o;
  logic [7:0]  status_o;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
  localparam logic [7:0] S_NONE = 8'h00, S_ZERO = 8'h01, S_INF = 8'h02,
                         S_INV = 8'h04, S_INX = 8'h20, S_ZINX = 8'h21;

  r5fp_round_to_int_unit #(.EXP_W(8), .SIG_W(23)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .a_i      (a_i),
    .rnd_i    (rnd_i),
    .valid_o  (valid_o),
    .z_o      (z_o),
    .status_o (status_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic runVec(input string tag, input logic [31:0] a, input logic [2:0] rnd,
                        input logic [31:0] expZ, input logic [7:0] expS);
    @(negedge clk);
    a_i = a;
    rnd_i = rnd;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    chk({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
    chk({tag, ".z"}, z_o, expZ);
    chk({tag, ".status"}, {24'd0, status_o}, {24'd0, expS});
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst.valid", {31'd0, valid_o}, 32'd0);
    chk("rst.z", z_o, 32'd0);
    chk("rst.status", {24'd0, status_o}, 32'd0);
    reset = 1'b1;

    // mid-range rounding
    runVec("2.5rne", 32'h40200000, RNE, 32'h40000000, S_INX);
    runVec("2.5rmm", 32'h40200000, RMM, 32'h40400000, S_INX);
    runVec("2.5rup", 32'h40200000, RUP, 32'h40400000, S_INX);
    runVec("2.5rtz", 32'h40200000, RTZ, 32'h40000000, S_INX);
    runVec("2.5rdn", 32'h40200000, RDN, 32'h40000000, S_INX);
    runVec("2.5rm7", 32'h40200000, 3'd7, 32'h40000000, S_INX);
    runVec("m1.5rdn", 32'hBFC00000, RDN, 32'hC0000000, S_INX);
    runVec("m1.5rtz", 32'hBFC00000, RTZ, 32'hBF800000, S_INX);
    runVec("m1.5rup", 32'hBFC00000, RUP, 32'hBF800000, S_INX);
    runVec("m1.5rne", 32'hBFC00000, RNE, 32'hC0000000, S_INX);
    runVec("1.5rne", 32'h3FC00000, RNE, 32'h40000000, S_INX);
    runVec("3.5rne", 32'h40600000, RNE, 32'h40800000, S_INX);
    runVec("m2.7rup", 32'hC02CCCCD, RUP, 32'hC0000000, S_INX);
    runVec("1.0rne", 32'h3F800000, RNE, 32'h3F800000, S_NONE);
    runVec("maxfrac", 32'h4AFFFFFF, RNE, 32'h4B000000, S_INX);

    // |a| < 1
    runVec("0.5rne", 32'h3F000000, RNE, 32'h00000000, S_ZINX);
    runVec("0.5rmm", 32'h3F000000, RMM, 32'h3F800000, S_INX);
    runVec("m0.3rup", 32'hBE99999A, RUP, 32'h80000000, S_ZINX);
    runVec("sub.rup", 32'h00000001, RUP, 32'h3F800000, S_INX);
    runVec("0.75rtz", 32'h3F400000, RTZ, 32'h00000000, S_ZINX);
    runVec("m0.75rdn", 32'hBF400000, RDN, 32'hBF800000, S_INX);
    runVec("0.25rmm", 32'h3E800000, RMM, 32'h00000000, S_ZINX);

    // already integral, specials
    runVec("2p23", 32'h4B000001, RUP, 32'h4B000001, S_NONE);
    runVec("inf", 32'h7F800000, RDN, 32'h7F800000, S_INF);
    runVec("mzero", 32'h80000000, RUP, 32'h80000000, S_ZERO);
    runVec("snan", 32'h7F800001, RNE, 32'h7FC00000, S_INV);
    runVec("qnan", 32'hFFC00000, RTZ, 32'h7FC00000, S_NONE);

    // hold while valid_i is low
    @(negedge clk);
    a_i = 32'h40200000;
    rnd_i = RMM;
    @(negedge clk);
    chk("hold.valid", {31'd0, valid_o}, 32'd0);
    chk("hold.z", z_o, 32'h7FC00000);

    // back-to-back stream
    @(negedge clk);
    a_i = 32'h40200000; rnd_i = RNE; valid_i = 1'b1;
    @(negedge clk);
    chk("b2b1.z", z_o, 32'h40000000);
    chk("b2b1.valid", {31'd0, valid_o}, 32'd1);
    a_i = 32'h40200000; rnd_i = RUP;
    @(negedge clk);
    chk("b2b2.z", z_o, 32'h40400000);
    a_i = 32'hBFC00000; rnd_i = RTZ;
    @(negedge clk);
    chk("b2b3.z", z_o, 32'hBF800000);
    valid_i = 1'b0;
    @(negedge clk);
    chk("b2b.end", {31'd0, valid_o}, 32'd0);

    // asynchronous reset in the middle of a stream
    a_i = 32'h40200000; rnd_i = RMM; valid_i = 1'b1;
    @(posedge clk);
    #1;
    chk("mid.pre", z_o, 32'h40400000);
    #1 reset = 1'b0;
    #1;
    chk("mid.z", z_o, 32'd0);
    chk("mid.status", {24'd0, status_o}, 32'd0);
    chk("mid.valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    valid_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post.valid", {31'd0, valid_o}, 32'd0);
    runVec("post.vec", 32'hBFC00000, RNE, 32'hC0000000, S_INX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
